ibex_alu_mc: RTL and testbench

IBEX_ALU_MC -- requirements
Module: ibex_alu_mc

---
 rtl/ibex_alu_mc.sv | 133 +++++++++++++
 tb/tb_ibex_alu_mc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Most operators finish in one cycle. ROL/ROR take a second cycle (ROT2) to merge in the wrapped bits.
module ibex_alu_mc #(
    parameter int WIDTH  = 32,
    parameter int ROTATE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       operator_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             comparison_result_o,
    output logic             is_equal_result_o,
    output logic             busy_o
);
    localparam int AW = $clog2(WIDTH);
    localparam logic [AW:0] W_L = (AW+1)'(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL = 4'd6,  OP_SRA = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8,  OP_ROR  = 4'd9,  OP_SLT = 4'd10, OP_SLTU = 4'd11;
    localparam logic [3:0] OP_EQ   = 4'd12, OP_NE   = 4'd13;

    typedef enum logic [1:0] {IDLE, ROT2, DONE} state_t;

    state_t           state, state_d;
    logic             accept;
    logic [AW-1:0]    amt;
    logic             is_sub, is_rot, lt, lt_s, lt_u, eq;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res, rot_first, rot_res;
    logic             alu_cmp;

    logic [WIDTH-1:0] result_q, rot_q, a_q;
    logic [AW-1:0]    amt_q;
    logic             cmp_q, eq_q, ror_q;

    assign ready_o = !rst_i && ((state == IDLE) || (state == DONE && ready_i));
    assign accept  = valid_i && ready_o;
    assign valid_o = (state == DONE);
    assign busy_o  = (state != IDLE);

    assign result_o            = result_q;
    assign comparison_result_o = cmp_q;
    assign is_equal_result_o   = eq_q;

    assign amt    = operand_b_i[AW-1:0];
    assign is_sub = (operator_i == OP_SUB) || (operator_i == OP_SLT) || (operator_i == OP_SLTU);
    assign is_rot = (ROTATE != 0) && ((operator_i == OP_ROL) || (operator_i == OP_ROR));
    assign eq     = (operand_a_i == operand_b_i);

    // Shared adder: the subtract path also feeds the less-than flags.
    assign sum  = {1'b0, operand_a_i} + {1'b0, (is_sub ? ~operand_b_i : operand_b_i)}
                + {{WIDTH{1'b0}}, is_sub};
    assign lt_u = ~sum[WIDTH];
    assign lt_s = (operand_a_i[WIDTH-1] ^ operand_b_i[WIDTH-1]) ? operand_a_i[WIDTH-1]
                                                                : sum[WIDTH-1];
    assign lt   = (operator_i == OP_SLT) ? lt_s : lt_u;

    assign rot_first = (operator_i == OP_ROR) ? (operand_a_i >> amt) : (operand_a_i << amt);

    // With amt==0 the first half already equals a, so the wrap term is suppressed
    // instead of shifting by WIDTH.
    always_comb begin
        rot_res = rot_q;
        if (amt_q != '0) begin
            if (ror_q) rot_res = rot_q | (a_q << (W_L - {1'b0, amt_q}));
            else       rot_res = rot_q | (a_q >> (W_L - {1'b0, amt_q}));
        end
    end

    always_comb begin
        alu_res = '0;
        alu_cmp = 1'b0;
        case (operator_i)
            OP_ADD, OP_SUB: alu_res = sum[WIDTH-1:0];
            OP_AND:         alu_res = operand_a_i & operand_b_i;
            OP_OR:          alu_res = operand_a_i | operand_b_i;
            OP_XOR:         alu_res = operand_a_i ^ operand_b_i;
            OP_SLL:         alu_res = operand_a_i << amt;
            OP_SRL:         alu_res = operand_a_i >> amt;
            OP_SRA:         alu_res = $unsigned($signed(operand_a_i) >>> amt);
            OP_SLT, OP_SLTU: begin
                alu_res = {{(WIDTH-1){1'b0}}, lt};
                alu_cmp = lt;
            end
            OP_EQ:          alu_cmp = eq;
            OP_NE:          alu_cmp = !eq;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept) state_d = is_rot ? ROT2 : DONE;
            ROT2: state_d = DONE;
            DONE: if (ready_i) state_d = accept ? (is_rot ? ROT2 : DONE) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            result_q <= '0;
            cmp_q    <= 1'b0;
            eq_q     <= 1'b0;
            rot_q    <= '0;
            a_q      <= '0;
            amt_q    <= '0;
            ror_q    <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                result_q <= alu_res;
                cmp_q    <= alu_cmp;
                eq_q     <= eq;
                rot_q    <= is_rot ? rot_first : '0;
                a_q      <= operand_a_i;
                amt_q    <= amt;
                ror_q    <= (operator_i == OP_ROR);
            end else if (state == ROT2) begin
                result_q <= rot_res;
            end
        end
    end
endmodule

// File: tb/tb_ibex_alu_mc.sv
// Directed scoreboard bench for ibex_alu_mc: main 32-bit rotate-enabled instance,
// plus a 32-bit ROTATE=0 instance and an 8-bit instance for parameter corner cases.
module tb_ibex_alu_mc;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
    localparam logic [3:0] SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, ROL = 4'd8, ROR = 4'd9;
    localparam logic [3:0] SLT = 4'd10, SLTU = 4'd11, EQ = 4'd12, NE = 4'd13;

    typedef struct {
        logic [31:0] res;
        logic        cmp;
        logic        eq;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        m_valid, m_rdy, m_vo, m_rdyi, m_cmp, m_eq, m_busy;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_res;

    logic        n_valid, n_rdy, n_vo, n_rdyi, n_cmp, n_eq, n_busy;
    logic [3:0]  n_op;
    logic [31:0] n_a, n_b, n_res;

    logic        e_valid, e_rdy, e_vo, e_rdyi, e_cmp, e_eq, e_busy;
    logic [3:0]  e_op;
    logic [7:0]  e_a, e_b, e_res;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sbq[$];
    exp_t mon_e;

    ibex_alu_mc #(.WIDTH(32), .ROTATE(1)) u_main (
        .clk_i(clk), .rst_i(rst), .valid_i(m_valid), .ready_o(m_rdy), .operator_i(m_op),
        .operand_a_i(m_a), .operand_b_i(m_b), .valid_o(m_vo), .ready_i(m_rdyi),
        .result_o(m_res), .comparison_result_o(m_cmp), .is_equal_result_o(m_eq), .busy_o(m_busy));

    ibex_alu_mc #(.WIDTH(32), .ROTATE(0)) u_norot (
        .clk_i(clk), .rst_i(rst), .valid_i(n_valid), .ready_o(n_rdy), .operator_i(n_op),
        .operand_a_i(n_a), .operand_b_i(n_b), .valid_o(n_vo), .ready_i(n_rdyi),
        .result_o(n_res), .comparison_result_o(n_cmp), .is_equal_result_o(n_eq), .busy_o(n_busy));

    ibex_alu_mc #(.WIDTH(8), .ROTATE(1)) u_w8 (
        .clk_i(clk), .rst_i(rst), .valid_i(e_valid), .ready_o(e_rdy), .operator_i(e_op),
        .operand_a_i(e_a), .operand_b_i(e_b), .valid_o(e_vo), .ready_i(e_rdyi),
        .result_o(e_res), .comparison_result_o(e_cmp), .is_equal_result_o(e_eq), .busy_o(e_busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Results leave the main DUT in order; each is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && m_vo && m_rdyi) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", 32'(m_vo), 32'(0));
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_result", m_res, mon_e.res);
                chk("sb_cmp", 32'(m_cmp), 32'(mon_e.cmp));
                chk("sb_eq", 32'(m_eq), 32'(mon_e.eq));
            end
        end
    end

    task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] r, input logic c, input logic q);
        int n;
        exp_t e;
        m_valid = 1'b1; m_op = o; m_a = x; m_b = y;
        e.res = r; e.cmp = c; e.eq = q;
        sbq.push_back(e);
        n = 0;
        @(negedge clk);
        while (!m_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'(m_rdy), 32'(1));
        @(posedge clk); #1;
        // Scramble operands so a design that fails to capture them shows up.
        m_valid = 1'b0; m_a = $urandom; m_b = $urandom; m_op = 4'($urandom_range(0, 15));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || m_busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("drain_timeout", 32'(m_busy), 32'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        m_valid = 0; m_op = 0; m_a = 0; m_b = 0; m_rdyi = 1;
        n_valid = 0; n_op = 0; n_a = 0; n_b = 0; n_rdyi = 1;
        e_valid = 0; e_op = 0; e_a = 0; e_b = 0; e_rdyi = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", 32'(m_rdy), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(m_vo), 32'(0));
        chk("rst_busy", 32'(m_busy), 32'(0));
        chk("rst_result", m_res, 32'(0));
        chk("rst_cmp", 32'(m_cmp), 32'(0));
        chk("rst_eq", 32'(m_eq), 32'(0));
        chk("rst_ready", 32'(m_rdy), 32'(1));
        @(posedge clk); #1;

        send(SUB, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        @(negedge clk);
        chk("sub_latency_valid", 32'(m_vo), 32'(1));
        drain();

        send(ROL, 32'h8000_0001, 32'h4, 32'h0000_0018, 1'b0, 1'b0);
        @(negedge clk);
        chk("rol_rot2_busy", 32'(m_busy), 32'(1));
        chk("rol_rot2_valid", 32'(m_vo), 32'(0));
        @(negedge clk);
        chk("rol_done_busy", 32'(m_busy), 32'(1));
        chk("rol_done_valid", 32'(m_vo), 32'(1));
        drain();
        send(ROR, 32'h8000_0001, 32'h4, 32'h1800_0000, 1'b0, 1'b0);
        send(ROL, 32'h8000_0001, 32'h20, 32'h8000_0001, 1'b0, 1'b0);
        send(SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b1, 1'b0);
        send(SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0);
        drain();

        // Back-to-back single-cycle stream.
        send(ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0);
        send(AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0);
        send(OR_, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0);
        send(XOR_, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0);
        send(SLL, 32'h1, 32'h21, 32'h2, 1'b0, 1'b0);
        send(SRL, 32'h8000_0000, 32'h1F, 32'h1, 1'b0, 1'b0);
        send(SRA, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, 1'b0);
        send(EQ, 32'h7, 32'h7, 32'h0, 1'b1, 1'b1);
        send(NE, 32'h7, 32'h7, 32'h0, 1'b0, 1'b1);
        send(NE, 32'h7, 32'h8, 32'h0, 1'b1, 1'b0);
        send(4'd14, 32'h3, 32'h3, 32'h0, 1'b0, 1'b1);
        send(SLT, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        send(SLTU, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
        send(SUB, 32'h9, 32'h9, 32'h0, 1'b0, 1'b1);
        drain();

        // Backpressure: result must hold and new requests must wait.
        m_rdyi = 1'b0;
        send(ADD, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0);
        m_valid = 1'b1; m_op = XOR_; m_a = 32'h6; m_b = 32'h3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(m_vo), 32'(1));
            chk("hold_result", m_res, 32'h3);
            chk("hold_ready", 32'(m_rdy), 32'(0));
            @(posedge clk); #1;
        end
        begin
            exp_t e;
            e.res = 32'h5; e.cmp = 1'b0; e.eq = 1'b0;
            sbq.push_back(e);
        end
        m_rdyi = 1'b1;
        @(negedge clk);
        chk("release_ready", 32'(m_rdy), 32'(1));
        @(posedge clk); #1;
        m_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 32'(m_vo), 32'(1));
        drain();

        // Reset while in ROT2 discards the rotate.
        m_valid = 1'b1; m_op = ROR; m_a = 32'h8000_0001; m_b = 32'h4;
        @(negedge clk);
        chk("ror_accept", 32'(m_rdy), 32'(1));
        @(posedge clk); #1;
        m_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("ror_in_rot2", 32'(m_busy), 32'(1));
        chk("ready_low_rst", 32'(m_rdy), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(m_vo), 32'(0));
        chk("post_rst_busy", 32'(m_busy), 32'(0));
        chk("post_rst_result", m_res, 32'h0);
        chk("post_rst_cmp", 32'(m_cmp), 32'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale_valid", 32'(m_vo), 32'(0));
        end
        @(posedge clk); #1;

        // ROTATE=0: rotate opcodes and illegal opcodes are single-cycle zeros.
        n_valid = 1'b1; n_op = ROL; n_a = 32'h8000_0001; n_b = 32'h4;
        @(negedge clk);
        chk("norot_ready", 32'(n_rdy), 32'(1));
        @(posedge clk); #1;
        n_valid = 1'b1; n_op = 4'd15; n_a = 32'h5; n_b = 32'h5;
        @(negedge clk);
        chk("norot_rol_valid", 32'(n_vo), 32'(1));
        chk("norot_rol_result", n_res, 32'h0);
        chk("norot_rol_cmp", 32'(n_cmp), 32'(0));
        @(posedge clk); #1;
        n_valid = 1'b0;
        @(negedge clk);
        chk("op15_valid", 32'(n_vo), 32'(1));
        chk("op15_result", n_res, 32'h0);
        chk("op15_cmp", 32'(n_cmp), 32'(0));
        chk("op15_eq", 32'(n_eq), 32'(1));
        @(posedge clk); #1;

        // WIDTH=8: shift amount uses only the low 3 bits of b.
        e_valid = 1'b1; e_op = SRA; e_a = 8'h80; e_b = 8'h09;
        @(posedge clk); #1;
        e_valid = 1'b1; e_op = ROL; e_a = 8'h81; e_b = 8'h01;
        @(negedge clk);
        chk("w8_sra_valid", 32'(e_vo), 32'(1));
        chk("w8_sra_result", 32'(e_res), 32'hC0);
        @(posedge clk); #1;
        e_valid = 1'b0;
        @(negedge clk);
        chk("w8_rol_rot2", 32'(e_vo), 32'(0));
        @(negedge clk);
        chk("w8_rol_valid", 32'(e_vo), 32'(1));
        chk("w8_rol_result", 32'(e_res), 32'h03);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
